cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Condition-flag register and branch-condition evaluator that consumes the ALU's negative/zero/overflow/carry_out flags. It holds the architectural NZCV state written by flag-setting instructions (ADDS, SUBS, ANDS), tracks how many flag-setting ops are still in flight, and resolves B.cond requests from decode once every older flag writer has retired. It sits between the execute-stage ALU (producer) and the fetch/decode branch logic (consumer).

## Interface
- MAX_PENDING, 3, maximum number of in-flight flag-setting ops. Counter width is CW = $clog2(MAX_PENDING+1).
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flag_issue  in  1  a flag-setting op, older than any branch presented this cycle, entered the pipeline.
- flag_we  in  1  a flag-setting op retires; write flags this cycle.
- negative, zero, overflow, carry_out  in  1 each  ALU flags, valid when flag_we=1.
- br_valid  in  1  B.cond request valid.
- br_cond  in  4  LEGv8 condition code.
- br_ready  out  1  unit can accept a request.
- br_resp_valid  out  1  one-cycle pulse: br_taken is valid.
- br_taken  out  1  condition result.
- nzcv  out  4  registered flags {N,Z,C,V}.
- pend_err  out  1  sticky: pending counter overflow or underflow.

## Operation
- Pending counter `pend`:
  - +1 on flag_issue; −1 on flag_we; both together leave it unchanged.
  - Increment at MAX_PENDING with no retire: counter holds and pend_err is set.
  - flag_we at 0: flags are still written, counter holds 0, pend_err is set.
- Flag register: on flag_we, nzcv <= {negative, zero, carry_out, overflow}.
- Effective pending: eff = pend − flag_we + flag_issue. A same-cycle flag_issue counts as older than the branch.
- Condition codes, with flag source F:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 HS: C. 3 LO: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !(C&!Z).
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: !(!Z&(N==V)).
  - E, F: 1.
- FSM states IDLE, WAIT, RESP. br_ready = (state==IDLE) & reset_n.
  - IDLE, on br_valid&br_ready:
    - Capture br_cond, snapshot `wcnt` = eff.
    - If the evaluate condition holds, evaluate now and go to RESP; otherwise go to WAIT.
  - WAIT:
    - Each flag_we decrements wcnt. flag_issue is ignored for wcnt, since those ops are younger than the branch; it still updates pend.
    - When the evaluate condition holds, evaluate and go to RESP.
  - RESP: br_resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Evaluate condition and flag source F depend on FLAGS_BYPASS_EN (see Configuration).
- Evaluation registers br_taken. br_taken holds its value until the next evaluation.

## Timing
- Reset (reset_n=0 at a rising edge) clears:
  - state to IDLE; nzcv, pend, wcnt, br_taken, br_resp_valid, pend_err to 0.
  - br_ready is 0 while reset_n is low.
- Reset mid-WAIT or mid-RESP drops the request with no response.
- No pending writers: accept at edge t, br_resp_valid high during cycle t+1.
- Pending writers, with bypass: br_resp_valid is high the cycle after the last older flag_we.
- Pending writers, without bypass: br_resp_valid is high two cycles after the last older flag_we.
- A flag_we in the RESP cycle updates nzcv but not br_taken.
- Back-to-back branches: next accept no earlier than the cycle after RESP, giving a minimum 2-cycle spacing.

## Configuration
- FLAGS_BYPASS_EN defined:
  - Evaluate when wcnt==0, or when wcnt==1 & flag_we.
  - F = the incoming flag_we flags in the final-retire cycle; otherwise F = nzcv.
- FLAGS_BYPASS_EN undefined:
  - Evaluate only when wcnt==0 with no flag_we in the same cycle.
  - F is always nzcv. This adds one cycle after the last retire.

## Test plan
- Reset and zero flags:
  - Stimulus: hold reset_n=0 with br_valid=1 for 2 cycles, then release and request EQ.
  - Response: br_ready=0 during reset. After release: nzcv=0, br_ready=1, and EQ gives br_taken=0 at t+1.
- SUBS equal, then NE:
  - Stimulus: flag_issue, next cycle flag_we with Z=1 C=1, then request NE.
  - Response: br_taken=0. HS on the same flags gives 1.
- Branch waits on two writers:
  - Stimulus: two flag_issue, branch GT accepted, flag_we (N=1,V=0), then flag_we (Z=0,N=1,V=1).
  - Response: br_taken=1, with resp 1 cycle after the second flag_we (bypass) or 2 cycles (no bypass).
- Younger issue during WAIT:
  - Stimulus: one pending writer, branch accepted, then flag_issue in WAIT.
  - Response: the response follows the first retire only. pend=1 afterward.
- Counter errors:
  - Stimulus: 4 flag_issue with MAX_PENDING=3. Separately, flag_we at pend=0.
  - Response: pend stays at 3 and pend_err=1. On the flag_we case, flags are written and pend_err=1.
- Exhaustive conditions:
  - Stimulus: all 16 br_cond × 16 nzcv values.
  - Response: matches the condition table. Codes E and F are always taken.

Source files
------------

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV condition-flag register and B.cond evaluator.
//
// Holds the architectural flags written by retiring flag-setting ops, counts the
// flag-setting ops still in flight, and resolves branch-condition requests once
// every older flag writer has retired.
//
// Optional feature (compile-time macro FLAGS_BYPASS_EN):
//   defined   - a branch may resolve in the cycle its last older writer retires,
//               using the retiring flags directly.
//   undefined - a branch resolves only from the registered flags, one cycle later.
//
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   synchronous active-low reset
//   flag_issue     in   flag-setting op entered the pipeline (older than any branch this cycle)
//   flag_we        in   flag-setting op retires; flags below are written
//   negative       in   ALU N flag
//   zero           in   ALU Z flag
//   overflow       in   ALU V flag
//   carry_out      in   ALU C flag
//   br_valid       in   branch request valid
//   br_cond        in   [3:0] condition code
//   br_ready       out  request can be accepted
//   br_resp_valid  out  one-cycle pulse, br_taken valid
//   br_taken       out  condition result, held until the next evaluation
//   nzcv           out  [3:0] registered flags {N,Z,C,V}
//   pend_err       out  sticky pending-counter overflow/underflow
module cond_flag_unit #(
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flag_issue,
  input  logic       flag_we,
  input  logic       negative,
  input  logic       zero,
  input  logic       overflow,
  input  logic       carry_out,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  output logic       br_ready,
  output logic       br_resp_valid,
  output logic       br_taken,
  output logic [3:0] nzcv,
  output logic       pend_err
);

  localparam int unsigned CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MaxPend = CW'(MAX_PENDING);
  localparam logic [CW:0]   MaxWide = (CW + 1)'(MAX_PENDING);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic [CW-1:0] pend_q, pend_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [3:0]    nzcv_q, nzcv_d;
  logic [3:0]    cond_q, cond_d;
  logic          taken_q, taken_d;
  logic          err_q, err_d;

  logic [3:0]    in_flags;
  logic [CW:0]   eff_sum, eff_net;
  logic [CW-1:0] eff;
  logic          eval_idle, eval_wait;
  logic [3:0]    src_idle, src_wait;

  assign in_flags = {negative, zero, carry_out, overflow};

  // Condition table over F = {N,Z,C,V}. Odd codes invert their even partner,
  // except 14/15 which are always taken.
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n    = f[3];
    z    = f[2];
    c    = f[1];
    v    = f[0];
    base = 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond[3:1] == 3'd7) begin
      return 1'b1;
    end
    return base ^ cond[0];
  endfunction

  // Older writers still outstanding after this cycle, as seen by a branch
  // accepted now: a same-cycle issue is older, a same-cycle retire is gone.
  always_comb begin
    eff_sum = {1'b0, pend_q} + (CW + 1)'(flag_issue);
    eff_net = eff_sum;
    if (flag_we && (eff_sum != '0)) begin
      eff_net = eff_sum - (CW + 1)'(1);
    end
    eff = (eff_net > MaxWide) ? MaxPend : eff_net[CW-1:0];
  end

  // Evaluate conditions and flag sources for the two places a branch resolves.
`ifdef FLAGS_BYPASS_EN
  always_comb begin
    eval_idle = (eff == '0);
    src_idle  = flag_we ? in_flags : nzcv_q;
    eval_wait = (wcnt_q == '0) || ((wcnt_q == CW'(1)) && flag_we);
    src_wait  = ((wcnt_q == CW'(1)) && flag_we) ? in_flags : nzcv_q;
  end
`else
  always_comb begin
    eval_idle = (eff == '0) && !flag_we;
    src_idle  = nzcv_q;
    eval_wait = (wcnt_q == '0) && !flag_we;
    src_wait  = nzcv_q;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (br_valid) begin
          state_d = eval_idle ? StResp : StWait;
        end
      end
      StWait: begin
        if (eval_wait) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    br_ready      = (state_q == StIdle) && reset_n;
    br_resp_valid = (state_q == StResp);
  end

  // Pending counter, flag register and branch datapath next state.
  always_comb begin
    pend_d  = pend_q;
    err_d   = err_q;
    nzcv_d  = nzcv_q;
    wcnt_d  = wcnt_q;
    cond_d  = cond_q;
    taken_d = taken_q;

    case ({flag_issue, flag_we})
      2'b10: begin
        if (pend_q == MaxPend) begin
          err_d = 1'b1;
        end else begin
          pend_d = pend_q + CW'(1);
        end
      end
      2'b01: begin
        if (pend_q == '0) begin
          err_d = 1'b1;
        end else begin
          pend_d = pend_q - CW'(1);
        end
      end
      default: pend_d = pend_q;
    endcase

    if (flag_we) begin
      nzcv_d = in_flags;
    end

    case (state_q)
      StIdle: begin
        if (br_valid) begin
          cond_d = br_cond;
          wcnt_d = eff;
          if (eval_idle) begin
            taken_d = eval_cond(br_cond, src_idle);
          end
        end
      end
      StWait: begin
        // Only older writers retire against wcnt; younger issues are ignored.
        if (flag_we && (wcnt_q != '0)) begin
          wcnt_d = wcnt_q - CW'(1);
        end
        if (eval_wait) begin
          taken_d = eval_cond(cond_q, src_wait);
        end
      end
      default: wcnt_d = wcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q  <= '0;
      err_q   <= 1'b0;
      nzcv_q  <= 4'h0;
      wcnt_q  <= '0;
      cond_q  <= 4'h0;
      taken_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      err_q   <= err_d;
      nzcv_q  <= nzcv_d;
      wcnt_q  <= wcnt_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
    end
  end

  assign br_taken = taken_q;
  assign nzcv     = nzcv_q;
  assign pend_err = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: stimulus pushes expected {taken, cycle}
// entries, a negedge monitor pops and compares on every br_resp_valid.
module tb_cond_flag_unit;

`ifdef FLAGS_BYPASS_EN
  localparam int unsigned ExtraLat = 0;
`else
  localparam int unsigned ExtraLat = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flag_issue, flag_we;
  logic       negative, zero, overflow, carry_out;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_ready, br_resp_valid, br_taken;
  logic [3:0] nzcv;
  logic       pend_err;

  always #5 clk = ~clk;

  cond_flag_unit #(.MAX_PENDING(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flag_issue    (flag_issue),
    .flag_we       (flag_we),
    .negative      (negative),
    .zero          (zero),
    .overflow      (overflow),
    .carry_out     (carry_out),
    .br_valid      (br_valid),
    .br_cond       (br_cond),
    .br_ready      (br_ready),
    .br_resp_valid (br_resp_valid),
    .br_taken      (br_taken),
    .nzcv          (nzcv),
    .pend_err      (pend_err)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        taken;
    int unsigned at;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expectation, value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (br_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got response taken=%0b with none expected (cycle %0d)",
                 br_taken, cyc);
      end else begin
        e = exp_q.pop_front();
        check("br_taken", 32'(br_taken), 32'(e.taken));
        check("resp_cycle", cyc, e.at);
      end
    end
  end

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !(cy && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic taken, input int unsigned edges);
    exp_t e;
    e.taken = taken;
    e.at    = cyc + edges;
    exp_q.push_back(e);
  endtask

  task automatic set_flags(input logic [3:0] f);
    {negative, zero, carry_out, overflow} = f;
  endtask

  // Wait (bounded) for every expected response, then return to IDLE.
  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  task automatic quick_branch(input logic [3:0] c, input logic taken);
    expect_resp(taken, 1);
    br_valid = 1'b1;
    br_cond  = c;
    tick();
    br_valid = 1'b0;
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    flag_issue = 1'b0;
    flag_we    = 1'b0;
    set_flags(4'h0);
    br_valid   = 1'b1;
    br_cond    = 4'h0;

    // Reset with a request held valid.
    #1;
    check("ready_in_reset0", 32'(br_ready), 32'd0);
    tick();
    check("ready_in_reset1", 32'(br_ready), 32'd0);
    tick();
    check("ready_in_reset2", 32'(br_ready), 32'd0);
    check("nzcv_reset", 32'(nzcv), 32'd0);
    check("pend_err_reset", 32'(pend_err), 32'd0);
    check("resp_reset", 32'(br_resp_valid), 32'd0);
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(br_ready), 32'd1);
    expect_resp(1'b0, 1);  // EQ on Z=0
    tick();
    br_valid = 1'b0;
    drain();

    // SUBS equal: Z=1 C=1, then NE and HS.
    flag_issue = 1'b1;
    tick();
    flag_issue = 1'b0;
    flag_we    = 1'b1;
    set_flags(4'b0110);
    tick();
    flag_we = 1'b0;
    check("nzcv_subs", 32'(nzcv), 32'h6);
    quick_branch(4'h1, 1'b0);
    quick_branch(4'h2, 1'b1);

    // GT waits on two older writers.
    flag_issue = 1'b1;
    tick();
    tick();
    flag_issue = 1'b0;
    br_valid   = 1'b1;
    br_cond    = 4'hC;
    tick();
    br_valid = 1'b0;
    check("ready_in_wait", 32'(br_ready), 32'd0);
    flag_we = 1'b1;
    set_flags(4'b1000);
    tick();
    set_flags(4'b1001);
    expect_resp(1'b1, 1 + ExtraLat);
    tick();
    flag_we = 1'b0;
    drain();
    check("nzcv_gt", 32'(nzcv), 32'h9);

    // Younger issue during WAIT does not extend the wait.
    flag_issue = 1'b1;
    tick();
    flag_issue = 1'b0;
    br_valid   = 1'b1;
    br_cond    = 4'h0;
    tick();
    br_valid   = 1'b0;
    flag_issue = 1'b1;
    tick();
    flag_issue = 1'b0;
    flag_we    = 1'b1;
    set_flags(4'b0100);
    expect_resp(1'b1, 1 + ExtraLat);
    tick();
    flag_we = 1'b0;
    drain();
    // The younger op is still pending: NE must wait for its retire.
    br_valid = 1'b1;
    br_cond  = 4'h1;
    tick();
    br_valid = 1'b0;
    tick();
    flag_we = 1'b1;
    set_flags(4'b0000);
    expect_resp(1'b1, 1 + ExtraLat);
    tick();
    flag_we = 1'b0;
    drain();

    // Overflow: four issues saturate pend at 3.
    check("pend_err_clean", 32'(pend_err), 32'd0);
    flag_issue = 1'b1;
    repeat (4) tick();
    flag_issue = 1'b0;
    check("pend_err_ovf", 32'(pend_err), 32'd1);
    br_valid = 1'b1;
    br_cond  = 4'hB;
    tick();
    br_valid = 1'b0;
    flag_we  = 1'b1;
    set_flags(4'b0001);
    tick();
    set_flags(4'b0101);
    tick();
    set_flags(4'b1000);
    expect_resp(1'b1, 1 + ExtraLat);
    tick();
    flag_we = 1'b0;
    drain();

    // Reset mid-WAIT drops the request silently.
    flag_issue = 1'b1;
    tick();
    flag_issue = 1'b0;
    br_valid   = 1'b1;
    br_cond    = 4'hE;
    tick();
    br_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    check("pend_err_cleared", 32'(pend_err), 32'd0);
    check("nzcv_cleared", 32'(nzcv), 32'd0);
    tick();
    tick();

    // Underflow: flag_we at pend=0 still writes flags.
    flag_we = 1'b1;
    set_flags(4'b1010);
    tick();
    flag_we = 1'b0;
    check("nzcv_underflow", 32'(nzcv), 32'hA);
    check("pend_err_unf", 32'(pend_err), 32'd1);
    quick_branch(4'h4, 1'b1);  // pend stayed 0, so immediate

    // Every condition against every flag value.
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fv;
      fv         = 4'(f);
      flag_issue = 1'b1;
      tick();
      flag_issue = 1'b0;
      flag_we    = 1'b1;
      set_flags(fv);
      tick();
      flag_we = 1'b0;
      check("nzcv_sweep", 32'(nzcv), 32'(fv));
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cv;
        cv = 4'(c);
        quick_branch(cv, cond_model(cv, fv));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
